move_select_ctrl: RTL
=====================

Name: move_select_ctrl

Overview:
- Sequential best-move selector for the search engine. Accepts one 6-bit move score per cycle over a valid/ready handshake and tracks the running maximum and the index of the move that produced it.
- Replaces the 64-input combinational max tree where score producers are serial.
- Tie rule matches the combinational arbiter: on equal scores the later input wins.

Parameters:
- SCORE_W, 6, score width in bits (unsigned)
- N_MOVES, 64, scores per scan
- IDX_W, 6, index/count width; must satisfy 2**IDX_W >= N_MOVES

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin scan; sampled only in IDLE
- score_valid  input  1  score_in carries a score this cycle
- score_in  input  SCORE_W  unsigned move score
- score_ready  output  1  high in SCAN only; a transfer occurs when score_valid && score_ready
- busy  output  1  high in SCAN and DONE
- done  output  1  one-cycle pulse when the result is final
- best_score  output  SCORE_W  maximum accepted score
- best_idx  output  IDX_W  0-based index of the accepted score that produced best_score
- count  output  IDX_W+1  number of scores accepted in the current scan

Behaviour:
- Reset: state=IDLE; score_ready=0, busy=0, done=0, best_score=0, best_idx=0, count=0.
  - rst has priority over all inputs and aborts a scan mid-operation with no done pulse.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - When start=1, on the next edge go to SCAN and clear best_score, best_idx and count to 0. Clear takes effect in the same edge.
  - Results from the previous scan hold in IDLE until start.
- SCAN:
  - score_ready=1 combinationally from state.
  - On each transfer:
    - first transfer (count==0): load best_score=score_in and best_idx=0 unconditionally;
    - later transfers: if score_in >= best_score, load best_score=score_in and best_idx=count;
    - count increments.
  - score_valid=0 cycles: no change. Gaps are allowed indefinitely.
  - The transfer that makes count==N_MOVES moves the FSM to DONE on the same edge. score_ready is 0 in the following cycle, and further scores are not accepted.
  - start is ignored in SCAN and DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
  - Latency: done asserts 1 cycle after the final transfer edge.
- Comparison is unsigned over SCORE_W bits. count never wraps; it saturates at N_MOVES by construction.
- Outputs are registered, except score_ready, busy and done, which decode state.

Optional Feature:
- Macro: MOVE_SEL_ABORT_EN.
- Defined:
  - Adds input abort (1 bit) and output aborted (1 bit; reset 0).
  - abort=1 in SCAN goes to DONE on the next edge. Any transfer in that same cycle is still accepted.
  - aborted is set when the FSM enters DONE via abort and holds with the partial result until the next start edge, which clears it.
  - abort in IDLE or DONE is ignored.
  - If count==0 at abort: best_score=0, best_idx=0.
  - If the final (N_MOVES-th) transfer and abort occur in the same cycle, the scan completes normally and aborted=0.
- Not defined: the abort and aborted ports do not exist. A scan ends only on N_MOVES transfers or rst.

Test Plan:
- Basic max: start, then 64 back-to-back scores where score[i]=i except score[17]=63 -> done 1 cycle after the 64th transfer; best_score=63, best_idx=63. Tie, later wins: score[63]=63.
- Tie rule: all 64 scores = 5 -> best_score=5, best_idx=63. Then rerun with score[3]=40 and others 0 -> best_score=40, best_idx=3.
- Handshake gaps: score_valid toggled 1/0 randomly across 64 transfers with maximum 50 at index 20 -> best_idx=20, count=64.
  - No transfer is counted while score_valid=0.
  - score_ready=0 in IDLE and DONE.
  - start asserted mid-scan has no effect.
- Zero inputs: 64 scores of 0 -> best_score=0, best_idx=63, done a single pulse.
- Reset mid-scan: rst after 10 transfers -> next cycle all outputs at reset values, no done pulse. A new start with 64 scores of value 9 -> best_score=9.
- MOVE_SEL_ABORT_EN:
  - abort after 5 transfers (scores 3,8,8,2,1) -> done pulse with best_score=8, best_idx=2, count=5, aborted=1; the next start clears aborted.
  - abort coincident with the 64th transfer -> aborted=0.

Source files
------------

// File: rtl/move_select_ctrl.sv
// move_select_ctrl: serial best-move selector.
// Accepts one unsigned score per valid/ready transfer and keeps the running
// maximum plus the index of the transfer that produced it (ties: later wins).
// Optional build macro MOVE_SEL_ABORT_EN adds an abort input and an aborted
// status flag; without it a scan ends only after N_MOVES transfers or rst.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; previous scan result held on outputs
// SCAN  | accepting scores, score_ready high
// DONE  | one-cycle done pulse, result final; returns to IDLE
module move_select_ctrl #(
  parameter int SCORE_W = 6,
  parameter int N_MOVES = 64,
  parameter int IDX_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score_in,
`ifdef MOVE_SEL_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic               score_ready,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] best_score,
  output logic [IDX_W-1:0]   best_idx,
  output logic [IDX_W:0]     count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(N_MOVES - 1);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);

  state_t state, state_d;
  logic   start_scan;
  logic   xfer;
  logic   last_xfer;

  assign start_scan = (state == IDLE) && start;
  assign xfer       = (state == SCAN) && score_valid;
  assign last_xfer  = xfer && (count == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state decode and state-decoded handshake/status outputs.
  always_comb begin
    state_d     = state;
    score_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_d = SCAN;
      end
      SCAN: begin
        score_ready = 1'b1;
        busy        = 1'b1;
        if (last_xfer) state_d = DONE;
`ifdef MOVE_SEL_ABORT_EN
        else if (abort) state_d = DONE;
`endif
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Running maximum, its index and the transfer count.
  always_ff @(posedge clk) begin
    if (rst || start_scan) begin
      best_score <= '0;
      best_idx   <= '0;
      count      <= '0;
    end else if (xfer) begin
      // First transfer loads unconditionally; >= makes the later of equal scores win.
      if ((count == '0) || (score_in >= best_score)) begin
        best_score <= score_in;
        best_idx   <= count[IDX_W-1:0];
      end
      count <= count + CNT_ONE;
    end
  end

`ifdef MOVE_SEL_ABORT_EN
  // Flag a scan that ended early; a coincident final transfer counts as normal completion.
  always_ff @(posedge clk) begin
    if (rst || start_scan)
      aborted <= 1'b0;
    else if ((state == SCAN) && abort && !last_xfer)
      aborted <= 1'b1;
  end
`endif

endmodule
